// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
// Gathers writeback results from NCH producer channels. Each channel has a
// DEPTH-entry FIFO. Every enabled cycle, one non-empty FIFO is granted
// round-robin and its head entry is turned into a register-file write and/or a
// CSR write. The write ports are combinational from the FIFO heads and the
// grant. All state lives in registers.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   enabled                  stage enable (0: no pop, no write; pushes still taken)
//   flush                    synchronous clear of every FIFO
//   in_valid/in_ready [NCH]  per-channel push handshake
//   in_rd_addr  [5*NCH]      destination register, channel i at [5i+4:5i]
//   in_rd_data  [XLEN*NCH]   register write data
//   in_csr_en   [NCH]        entry carries a CSR write
//   in_csr_addr [12*NCH]     CSR address
//   in_csr_data [XLEN*NCH]   CSR write data
//   reg_w_*                  register-file write port
//   csr_w_*                  CSR write port
//   busy                     some FIFO holds an entry
// -----------------------------------------------------------------------------
module writeback_arbiter #(
    parameter int NCH   = 3,
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enabled,
    input  logic                 flush,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [5*NCH-1:0]     in_rd_addr,
    input  logic [XLEN*NCH-1:0]  in_rd_data,
    input  logic [NCH-1:0]       in_csr_en,
    input  logic [12*NCH-1:0]    in_csr_addr,
    input  logic [XLEN*NCH-1:0]  in_csr_data,
    output logic                 reg_w_enabled,
    output logic [4:0]           reg_w_addr,
    output logic [XLEN-1:0]      reg_w_data,
    output logic                 csr_w_enabled,
    output logic [11:0]          csr_w_addr,
    output logic [XLEN-1:0]      csr_w_data,
    output logic                 busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [PW-1:0]   wr_ptr_r [NCH];
    logic [PW-1:0]   rd_ptr_r [NCH];

    logic [4:0]      mem_rd_addr_r  [NCH][DEPTH];
    logic [XLEN-1:0] mem_rd_data_r  [NCH][DEPTH];
    logic            mem_csr_en_r   [NCH][DEPTH];
    logic [11:0]     mem_csr_addr_r [NCH][DEPTH];
    logic [XLEN-1:0] mem_csr_data_r [NCH][DEPTH];

    logic [GW-1:0]   last_grant_r;

    logic [NCH-1:0]  empty_s;
    logic [NCH-1:0]  full_s;
    logic [NCH-1:0]  push_s;
    logic [GW-1:0]   cand_s;
    logic [GW-1:0]   grant_idx_s;
    logic            grant_found_s;
    logic            grant_s;
    logic [AW-1:0]   head_ptr_s;
    logic [4:0]      head_rd_addr_s;
    logic [XLEN-1:0] head_rd_data_s;
    logic            head_csr_en_s;
    logic [11:0]     head_csr_addr_s;
    logic [XLEN-1:0] head_csr_data_s;

    // FIFO status flags and push acceptance; ready is held low during reset and flush.
    always_comb begin
        empty_s  = '0;
        full_s   = '0;
        in_ready = '0;
        push_s   = '0;
        for (int i = 0; i < NCH; i++) begin
            empty_s[i]  = (wr_ptr_r[i] == rd_ptr_r[i]);
            full_s[i]   = (wr_ptr_r[i][PW-1] != rd_ptr_r[i][PW-1]) &&
                          (wr_ptr_r[i][AW-1:0] == rd_ptr_r[i][AW-1:0]);
            in_ready[i] = ~full_s[i] & ~flush & ~rst;
            push_s[i]   = in_valid[i] & in_ready[i];
        end
    end

    assign busy = |(~empty_s);

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand_s = GW'((int'(last_grant_r) + k) % NCH);
            if (!grant_found_s && !empty_s[cand_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    assign grant_s    = grant_found_s & enabled & ~flush;
    assign head_ptr_s = rd_ptr_r[grant_idx_s][AW-1:0];

    assign head_rd_addr_s  = mem_rd_addr_r[grant_idx_s][head_ptr_s];
    assign head_rd_data_s  = mem_rd_data_r[grant_idx_s][head_ptr_s];
    assign head_csr_en_s   = mem_csr_en_r[grant_idx_s][head_ptr_s];
    assign head_csr_addr_s = mem_csr_addr_r[grant_idx_s][head_ptr_s];
    assign head_csr_data_s = mem_csr_data_r[grant_idx_s][head_ptr_s];

    // Write ports: driven from the granted head, zero whenever there is nothing to write.
    always_comb begin
        reg_w_enabled = 1'b0;
        reg_w_addr    = 5'd0;
        reg_w_data    = '0;
        csr_w_enabled = 1'b0;
        csr_w_addr    = 12'd0;
        csr_w_data    = '0;
        if (grant_s && (head_rd_addr_s != 5'd0)) begin
            reg_w_enabled = 1'b1;
            reg_w_addr    = head_rd_addr_s;
            reg_w_data    = head_rd_data_s;
        end else begin
            reg_w_enabled = 1'b0;
        end
        if (grant_s && head_csr_en_s) begin
            csr_w_enabled = 1'b1;
            csr_w_addr    = head_csr_addr_s;
            csr_w_data    = head_csr_data_s;
        end else begin
            csr_w_enabled = 1'b0;
        end
    end

    // FIFO pointers: flush empties everything; otherwise advance on push and on grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                wr_ptr_r[i] <= '0;
                rd_ptr_r[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < NCH; i++) begin
                wr_ptr_r[i] <= '0;
                rd_ptr_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (push_s[i]) begin
                    wr_ptr_r[i] <= wr_ptr_r[i] + PW'(1);
                end
                if (grant_s && (grant_idx_s == GW'(i))) begin
                    rd_ptr_r[i] <= rd_ptr_r[i] + PW'(1);
                end
            end
        end
    end

    // Round-robin history; NCH-1 after reset/flush gives channel 0 first priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= GW'(NCH - 1);
        end else if (flush) begin
            last_grant_r <= GW'(NCH - 1);
        end else if (grant_s) begin
            last_grant_r <= grant_idx_s;
        end
    end

    // FIFO storage; contents are qualified by the pointers so they are not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (push_s[i]) begin
                mem_rd_addr_r[i][wr_ptr_r[i][AW-1:0]]  <= in_rd_addr[5*i +: 5];
                mem_rd_data_r[i][wr_ptr_r[i][AW-1:0]]  <= in_rd_data[XLEN*i +: XLEN];
                mem_csr_en_r[i][wr_ptr_r[i][AW-1:0]]   <= in_csr_en[i];
                mem_csr_addr_r[i][wr_ptr_r[i][AW-1:0]] <= in_csr_addr[12*i +: 12];
                mem_csr_data_r[i][wr_ptr_r[i][AW-1:0]] <= in_csr_data[XLEN*i +: XLEN];
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

    localparam int NCH   = 3;
    localparam int DEPTH = 2;
    localparam int XLEN  = 32;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        csr_en;
        logic [11:0] csr_addr;
        logic [31:0] csr_data;
    } ent_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                enabled;
    logic                flush;
    logic [NCH-1:0]      in_valid;
    logic [NCH-1:0]      in_ready;
    logic [5*NCH-1:0]    in_rd_addr;
    logic [XLEN*NCH-1:0] in_rd_data;
    logic [NCH-1:0]      in_csr_en;
    logic [12*NCH-1:0]   in_csr_addr;
    logic [XLEN*NCH-1:0] in_csr_data;
    logic                reg_w_enabled;
    logic [4:0]          reg_w_addr;
    logic [XLEN-1:0]     reg_w_data;
    logic                csr_w_enabled;
    logic [11:0]         csr_w_addr;
    logic [XLEN-1:0]     csr_w_data;
    logic                busy;

    int total = 0;
    int bad   = 0;

    // reference model state
    ent_t mq [NCH][$];
    ent_t exp_q [$];
    int   lg_m;

    // stimulus for the next cycle
    logic [NCH-1:0] v_valid;
    logic           v_en;
    logic           v_flush;
    ent_t           v_ent [NCH];

    writeback_arbiter #(.NCH(NCH), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .enabled(enabled), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
        .in_csr_en(in_csr_en), .in_csr_addr(in_csr_addr), .in_csr_data(in_csr_data),
        .reg_w_enabled(reg_w_enabled), .reg_w_addr(reg_w_addr), .reg_w_data(reg_w_data),
        .csr_w_enabled(csr_w_enabled), .csr_w_addr(csr_w_addr), .csr_w_data(csr_w_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        v_valid = '0;
        v_en    = 1'b1;
        v_flush = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            v_ent[i] = '{rd: 5'd0, data: 32'd0, csr_en: 1'b0, csr_addr: 12'd0, csr_data: 32'd0};
        end
    endtask

    task automatic set_ent(input int ch, input logic [4:0] rd, input logic [31:0] data,
                           input logic ce, input logic [11:0] ca, input logic [31:0] cd);
        v_valid[ch] = 1'b1;
        v_ent[ch]   = '{rd: rd, data: data, csr_en: ce, csr_addr: ca, csr_data: cd};
    endtask

    // One clock cycle: drive, predict, check ready/busy, then advance the model.
    task automatic step();
        logic [NCH-1:0] rdy;
        logic           busy_m;
        int             g;
        int             c;
        ent_t           e;
        @(negedge clk);
        in_valid = v_valid;
        enabled  = v_en;
        flush    = v_flush;
        for (int i = 0; i < NCH; i++) begin
            in_rd_addr[5*i +: 5]       = v_ent[i].rd;
            in_rd_data[XLEN*i +: XLEN] = v_ent[i].data;
            in_csr_en[i]               = v_ent[i].csr_en;
            in_csr_addr[12*i +: 12]    = v_ent[i].csr_addr;
            in_csr_data[XLEN*i +: XLEN] = v_ent[i].csr_data;
        end
        busy_m = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            rdy[i] = (mq[i].size() < DEPTH) && !v_flush;
            if (mq[i].size() > 0) busy_m = 1'b1;
        end
        g = -1;
        if (v_en && !v_flush) begin
            for (int k = 1; k <= NCH; k++) begin
                c = (lg_m + k) % NCH;
                if (g < 0 && mq[c].size() > 0) g = c;
            end
        end
        if (g >= 0) begin
            e = mq[g][0];
            if (e.rd != 5'd0 || e.csr_en) exp_q.push_back(e);
        end
        #1;
        chk("in_ready", in_ready, rdy);
        chk("busy", busy, busy_m);
        if (v_flush) begin
            for (int i = 0; i < NCH; i++) mq[i].delete();
            lg_m = NCH - 1;
        end else begin
            if (g >= 0) begin
                e    = mq[g].pop_front();
                lg_m = g;
            end
            for (int i = 0; i < NCH; i++) begin
                if (v_valid[i] && rdy[i]) mq[i].push_back(v_ent[i]);
            end
        end
    endtask

    // Monitor: every write the DUT presents must match the oldest predicted write.
    ent_t em;
    always begin
        @(negedge clk);
        #2;
        if (reg_w_enabled || csr_w_enabled) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_write: got reg_we=%0b rd=%0d csr_we=%0b expected no write",
                         reg_w_enabled, reg_w_addr, csr_w_enabled);
            end else begin
                em = exp_q.pop_front();
                chk("reg_we",   reg_w_enabled, em.rd != 5'd0);
                chk("reg_addr", reg_w_addr, (em.rd != 5'd0) ? em.rd : 5'd0);
                chk("reg_data", reg_w_data, (em.rd != 5'd0) ? em.data : 32'd0);
                chk("csr_we",   csr_w_enabled, em.csr_en);
                chk("csr_addr", csr_w_addr, em.csr_en ? em.csr_addr : 12'd0);
                chk("csr_data", csr_w_data, em.csr_en ? em.csr_data : 32'd0);
            end
        end else begin
            if (exp_q.size() != 0) begin
                em = exp_q.pop_front();
                total++;
                bad++;
                $display("FAIL missing_write: got none expected rd=%0d data=%0h csr_en=%0b",
                         em.rd, em.data, em.csr_en);
            end
            chk("idle_reg_outs", {reg_w_addr, reg_w_data}, 37'd0);
            chk("idle_csr_outs", {csr_w_addr, csr_w_data}, 44'd0);
        end
    end

    initial begin
        rst         = 1'b1;
        enabled     = 1'b0;
        flush       = 1'b0;
        in_valid    = '0;
        in_rd_addr  = '0;
        in_rd_data  = '0;
        in_csr_en   = '0;
        in_csr_addr = '0;
        in_csr_data = '0;
        lg_m        = NCH - 1;
        idle_inputs();

        // reset state
        #2;
        chk("rst_in_ready", in_ready, 3'b000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_reg_we", reg_w_enabled, 1'b0);
        chk("rst_csr_we", csr_w_enabled, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // single push on ch0, written the following cycle
        set_ent(0, 5'd5, 32'hDEADBEEF, 1'b0, 12'd0, 32'd0);
        step();
        idle_inputs();
        repeat (2) step();

        // simultaneous bursts on all channels, twice
        for (int r = 0; r < 2; r++) begin
            set_ent(0, 5'd1, 32'h1111_0000 + r, 1'b0, 12'd0, 32'd0);
            set_ent(1, 5'd2, 32'h2222_0000 + r, 1'b0, 12'd0, 32'd0);
            set_ent(2, 5'd3, 32'h3333_0000 + r, 1'b0, 12'd0, 32'd0);
            step();
            idle_inputs();
            repeat (3) step();
        end

        // fill ch1 while disabled, then drain
        for (int p = 0; p < 3; p++) begin
            v_en = 1'b0;
            set_ent(1, 5'd7, 32'h0000_0A00 + p, 1'b0, 12'd0, 32'd0);
            step();
        end
        v_en = 1'b1;
        repeat (2) step();
        idle_inputs();
        repeat (4) step();

        // CSR-only entry
        set_ent(2, 5'd0, 32'h0, 1'b1, 12'h300, 32'h8);
        step();
        idle_inputs();
        repeat (2) step();

        // flush with two FIFOs occupied and a concurrent push
        v_en = 1'b0;
        set_ent(0, 5'd9, 32'h9, 1'b0, 12'd0, 32'd0);
        set_ent(1, 5'd10, 32'hA, 1'b1, 12'h341, 32'hB);
        step();
        idle_inputs();
        v_flush = 1'b1;
        set_ent(2, 5'd11, 32'hC, 1'b0, 12'd0, 32'd0);
        step();
        idle_inputs();
        repeat (3) step();

        // asynchronous reset while FIFOs hold entries
        v_en = 1'b0;
        set_ent(0, 5'd12, 32'hC0, 1'b0, 12'd0, 32'd0);
        set_ent(1, 5'd13, 32'hD0, 1'b0, 12'd0, 32'd0);
        set_ent(2, 5'd14, 32'hE0, 1'b1, 12'h305, 32'hE1);
        step();
        idle_inputs();
        step();
        #3;
        rst = 1'b1;
        #1;
        chk("arst_reg_we", reg_w_enabled, 1'b0);
        chk("arst_csr_we", csr_w_enabled, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_in_ready", in_ready, 3'b000);
        for (int i = 0; i < NCH; i++) mq[i].delete();
        lg_m     = NCH - 1;
        in_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) step();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            v_en    = ($urandom_range(0, 3) != 0);
            v_flush = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < NCH; i++) begin
                v_valid[i] = ($urandom_range(0, 1) == 1);
                v_ent[i].rd       = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                v_ent[i].data     = $urandom;
                v_ent[i].csr_en   = ($urandom_range(0, 2) == 0);
                v_ent[i].csr_addr = 12'($urandom_range(0, 4095));
                v_ent[i].csr_data = $urandom;
            end
            step();
        end
        idle_inputs();
        repeat (8) step();

        @(negedge clk);
        #4;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
